pmem_arbiter_n: RTL and testbench

Registered N-port arbiter that multiplexes cache-line read/write requests from several cache clients (I-cache, D-cache, prefetcher, …) onto one physical-memory port. It replaces the 2-port combinational I/D mux. Every grant is locked for the whole memory transaction, and the memory-side outputs are registered. Priority is selectable between fixed (lowest index wins) and round-robin.

---
 rtl/pmem_arbiter_n_if.sv | 32 +++
 rtl/pmem_arbiter_n.sv | 96 +++++++++
 tb/tb_pmem_arbiter_n.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_n_if.sv
// pmem_arbiter_n_if: client request bundle plus the single physical-memory port of the arbiter.
interface pmem_arbiter_n_if #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    logic [NUM_PORTS-1:0]            req_read;
    logic [NUM_PORTS-1:0]            req_write;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] req_address;
    logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata;
    logic [LINE_WIDTH-1:0]           req_rdata;
    logic [NUM_PORTS-1:0]            req_resp;
    logic [ADDR_WIDTH-1:0]           pmem_address;
    logic                            pmem_read;
    logic                            pmem_write;
    logic [LINE_WIDTH-1:0]           pmem_wdata;
    logic [LINE_WIDTH-1:0]           pmem_rdata;
    logic                            pmem_resp;
    logic                            grant_valid;
    logic [IDX_W-1:0]                grant_idx;
    modport slave (
        input  req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
        output req_rdata, req_resp, pmem_address, pmem_read, pmem_write, pmem_wdata,
               grant_valid, grant_idx
    );
    modport master (
        output req_read, req_write, req_address, req_wdata, pmem_rdata, pmem_resp,
        input  req_rdata, req_resp, pmem_address, pmem_read, pmem_write, pmem_wdata,
               grant_valid, grant_idx
    );
endinterface

// File: rtl/pmem_arbiter_n.sv
// pmem_arbiter_n: registered N-port arbiter locking one client onto the memory port per transaction.
module pmem_arbiter_n #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int RR_MODE    = 1,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input logic clk,
    input logic rst,
    pmem_arbiter_n_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t                state_q, state_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d, last_q, last_d, win;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [NUM_PORTS-1:0]  req;
    int                    start, j;

    always_comb begin
        req   = bus.req_read | bus.req_write;
        start = (RR_MODE != 0 && int'(last_q) != NUM_PORTS - 1) ? int'(last_q) + 1 : 0;
        win   = '0;
        j     = 0;
        // Scan farthest-first so the requester nearest to start is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = (start + k) % NUM_PORTS;
            if (req[IDX_W'(j)]) win = IDX_W'(j);
        end
    end

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: if (|req) begin
                gidx_d  = win;
                addr_d  = bus.req_address[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d = bus.req_wdata[int'(win)*LINE_WIDTH +: LINE_WIDTH];
                rd_d    = bus.req_read[win];
                wr_d    = !bus.req_read[win];
                state_d = BUSY;
            end
            BUSY: if (bus.pmem_resp) begin
                rdata_d = rd_q ? bus.pmem_rdata : rdata_q;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                last_d  = (RR_MODE != 0) ? gidx_q : last_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.req_rdata    = rdata_q;
    assign bus.grant_valid  = state_q != IDLE;
    assign bus.grant_idx    = gidx_q;
    assign bus.req_resp     = (state_q == RESP) ? (NUM_PORTS'(1) << gidx_q) : '0;
endmodule

// File: tb/tb_pmem_arbiter_n.sv
// tb_pmem_arbiter_n: directed checks on a round-robin arbiter, then lockstep random traffic
// against a round-robin and a fixed-priority instance with a transaction-level model.
module tb_pmem_arbiter_n;
    localparam int N = 4, LW = 64, AW = 32, K = 3;
    logic clk = 1'b0, rst = 1'b1;
    int n_chk = 0, n_pass = 0;
    logic op_rd[N][K], op_wr[N][K];
    logic [AW-1:0] op_ad[N][K];
    logic [LW-1:0] op_wd[N][K];
    int ha[N], hb[N];
    int last_a;
    logic [LW-1:0] prev_a, prev_b, d1, d2, r;

    always #5 clk = ~clk;

    pmem_arbiter_n_if #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) ia (), ib ();
    pmem_arbiter_n #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(1))
        dut_rr (.clk(clk), .rst(rst), .bus(ia.slave));
    pmem_arbiter_n #(.NUM_PORTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .RR_MODE(0))
        dut_fx (.clk(clk), .rst(rst), .bus(ib.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic rs, input logic [LW-1:0] d);
        ia.pmem_resp = rs; ib.pmem_resp = rs;
        ia.pmem_rdata = d; ib.pmem_rdata = d;
    endtask

    task automatic set_req(input int d, input int p, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [LW-1:0] wd);
        if (d == 0) begin
            ia.req_read[p] = rd; ia.req_write[p] = wr;
            ia.req_address[p*AW +: AW] = a; ia.req_wdata[p*LW +: LW] = wd;
        end else begin
            ib.req_read[p] = rd; ib.req_write[p] = wr;
            ib.req_address[p*AW +: AW] = a; ib.req_wdata[p*LW +: LW] = wd;
        end
    endtask

    task automatic drive_all();
        for (int p = 0; p < N; p++) begin
            if (ha[p] < K) set_req(0, p, op_rd[p][ha[p]], op_wr[p][ha[p]], op_ad[p][ha[p]], op_wd[p][ha[p]]);
            else set_req(0, p, 1'b0, 1'b0, '0, '0);
            if (hb[p] < K) set_req(1, p, op_rd[p][hb[p]], op_wr[p][hb[p]], op_ad[p][hb[p]], op_wd[p][hb[p]]);
            else set_req(1, p, 1'b0, 1'b0, '0, '0);
        end
    endtask

    // Next port after the previous winner, wrapping, that still has work queued.
    function automatic int rr_pick(input int last);
        for (int k = 1; k <= N; k++) if (ha[(last + k) % N] < K) return (last + k) % N;
        return -1;
    endfunction

    function automatic int fx_pick();
        for (int p = 0; p < N; p++) if (hb[p] < K) return p;
        return -1;
    endfunction

    initial begin
        int wa, wb, lat, kind;
        ia.req_read = '0; ia.req_write = '0; ia.req_address = '0; ia.req_wdata = '0;
        ib.req_read = '0; ib.req_write = '0; ib.req_address = '0; ib.req_wdata = '0;
        mem(1'b0, '0);
        d1 = 64'hDEAD_BEEF_0123_4567;
        d2 = 64'h0F0E_0D0C_0B0A_0908;
        tick(); tick();
        chk("reset_ctl_rr", {ia.pmem_read, ia.pmem_write, ia.req_resp, ia.grant_valid, ia.grant_idx}, 0);
        chk("reset_dat_rr", {ia.pmem_address, ia.pmem_wdata[31:0]}, 0);
        chk("reset_rdata_rr", ia.req_rdata, 0);
        chk("reset_ctl_fx", {ib.pmem_read, ib.pmem_write, ib.req_resp, ib.grant_valid, ib.grant_idx}, 0);
        rst = 1'b0;
        // single read on port 1, memory answers after 5 cycles
        set_req(0, 1, 1'b1, 1'b0, 32'h0000_1000, '0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            chk("rd_busy", {ia.pmem_read, ia.pmem_write, ia.grant_valid, ia.grant_idx, ia.req_resp}, {1'b1, 1'b0, 1'b1, 2'd1, 4'd0});
            chk("rd_addr", ia.pmem_address, 32'h0000_1000);
            if (c < 5) tick();
        end
        mem(1'b1, d1); tick(); mem(1'b0, '0);
        chk("rd_resp", {ia.pmem_read, ia.req_resp}, {1'b0, 4'b0010});
        chk("rd_data", ia.req_rdata, d1);
        set_req(0, 1, 1'b0, 1'b0, '0, '0);
        tick();
        chk("rd_idle", {ia.grant_valid, ia.req_resp, ib.req_resp}, 0);
        // write on port 0
        set_req(0, 0, 1'b0, 1'b1, 32'h0000_2000, {8{8'hA5}});
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk("wr_busy", {ia.pmem_read, ia.pmem_write, ia.pmem_address}, {1'b0, 1'b1, 32'h0000_2000});
            chk("wr_wdata", ia.pmem_wdata, {8{8'hA5}});
            if (c < 3) tick();
        end
        mem(1'b1, 64'h1111); tick(); mem(1'b0, '0);
        chk("wr_resp", {ia.pmem_write, ia.req_resp}, {1'b0, 4'b0001});
        chk("wr_rdata_kept", ia.req_rdata, d1);
        set_req(0, 0, 1'b0, 1'b0, '0, '0);
        tick();
        // stray memory response in IDLE
        mem(1'b1, 64'h5555); tick(); mem(1'b0, '0);
        chk("idle_resp_ignored", {ia.grant_valid, ia.req_resp, ia.pmem_read, ia.pmem_write}, 0);
        chk("idle_rdata_kept", ia.req_rdata, d1);
        // read and write together on port 2
        set_req(0, 2, 1'b1, 1'b1, 32'h0000_3000, 64'h77);
        tick();
        chk("rw_read_wins", {ia.pmem_read, ia.pmem_write, ia.grant_idx}, {1'b1, 1'b0, 2'd2});
        mem(1'b1, d2); tick(); mem(1'b0, '0);
        chk("rw_resp", {ia.req_resp, ia.req_rdata}, {4'b0100, d2});
        set_req(0, 2, 1'b0, 1'b0, '0, '0);
        tick();
        // grant lock, then reset in the middle of the transaction
        set_req(0, 1, 1'b1, 1'b0, 32'h0000_4000, '0);
        tick();
        chk("lock_grant", ia.grant_idx, 1);
        set_req(0, 0, 1'b1, 1'b0, 32'h0000_5000, '0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("lock_hold", {ia.grant_idx, ia.pmem_read, ia.pmem_address}, {2'd1, 1'b1, 32'h0000_4000});
        end
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", {ia.pmem_read, ia.pmem_write, ia.grant_valid, ia.req_resp}, 0);
        rst = 1'b0;
        set_req(0, 0, 1'b0, 1'b0, '0, '0);
        set_req(0, 1, 1'b0, 1'b0, '0, '0);
        tick();
        mem(1'b1, 64'h9999); tick(); mem(1'b0, '0);
        chk("late_resp_a", {ia.req_resp, ia.grant_valid}, 0);
        tick();
        chk("late_resp_b", {ia.req_resp, ia.grant_valid, ia.req_rdata}, 0);
        // random traffic: both instances receive the same per-port work lists
        for (int p = 0; p < N; p++) begin
            ha[p] = 0; hb[p] = 0;
            for (int i = 0; i < K; i++) begin
                kind = $urandom_range(0, 2);
                op_rd[p][i] = kind != 1;
                op_wr[p][i] = kind != 0;
                op_ad[p][i] = $urandom;
                op_wd[p][i] = {$urandom, $urandom};
            end
        end
        last_a = N - 1;
        prev_a = '0; prev_b = '0;
        for (int t = 0; t < N * K; t++) begin
            drive_all();
            wa = rr_pick(last_a);
            wb = fx_pick();
            tick();
            chk("grant_rr", ia.grant_idx, wa);
            chk("grant_fx", ib.grant_idx, wb);
            lat = $urandom_range(1, 4);
            for (int i = 1; i <= lat; i++) begin
                chk("bus_rr", {ia.pmem_read, ia.pmem_write, ia.pmem_address},
                    {op_rd[wa][ha[wa]], !op_rd[wa][ha[wa]], op_ad[wa][ha[wa]]});
                chk("wdata_rr", ia.pmem_wdata, op_wd[wa][ha[wa]]);
                chk("bus_fx", {ib.pmem_read, ib.pmem_write, ib.pmem_address},
                    {op_rd[wb][hb[wb]], !op_rd[wb][hb[wb]], op_ad[wb][hb[wb]]});
                chk("wdata_fx", ib.pmem_wdata, op_wd[wb][hb[wb]]);
                if (i < lat) tick();
            end
            r = {$urandom, $urandom};
            mem(1'b1, r); tick(); mem(1'b0, '0);
            if (op_rd[wa][ha[wa]]) prev_a = r;
            if (op_rd[wb][hb[wb]]) prev_b = r;
            chk("resp_rr", ia.req_resp, N'(1) << wa);
            chk("resp_fx", ib.req_resp, N'(1) << wb);
            chk("rdata_rr", ia.req_rdata, prev_a);
            chk("rdata_fx", ib.req_rdata, prev_b);
            ha[wa]++; hb[wb]++;
            last_a = wa;
            drive_all();
            tick();
            chk("back_idle", {ia.grant_valid, ia.req_resp, ib.grant_valid, ib.req_resp}, 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
